generic_fifo_flow: RTL



---
 rtl/generic_fifo_flow_pkg.sv | 13 +
 rtl/generic_2port_memory.sv | 39 +++
 rtl/generic_fifo_flow.sv | 132 +++++++++++++
 3 files changed

// File: rtl/generic_fifo_flow_pkg.sv
// Shared definitions for the generic_fifo_flow FIFO: read-mode constants and
// an address-width helper that never returns zero.
package generic_fifo_flow_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // A two-entry FIFO still needs one address bit; $clog2 alone would give 0 for depth 1.
  function automatic int safe_addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/generic_2port_memory.sv
// Simple dual-port storage: one synchronous write port and one read port that is
// either combinational or registered.
module generic_2port_memory
  import generic_fifo_flow_pkg::*;
#(
  parameter int GENERIC_MEM_DEPTH          = 8,
  parameter int GENERIC_MEM_DATA_WIDTH     = 32,
  parameter int GENERIC_MEM_REGISTERED_OUT = 0,
  localparam int GENERIC_MEM_ADDR_WIDTH    = safe_addr_width(GENERIC_MEM_DEPTH)
) (
  input  logic                              clk,
  input  logic                              i_wr_en,
  input  logic [GENERIC_MEM_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [GENERIC_MEM_DATA_WIDTH-1:0] i_wr_data,
  input  logic [GENERIC_MEM_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [GENERIC_MEM_DATA_WIDTH-1:0] o_rd_data
);

  logic [GENERIC_MEM_DATA_WIDTH-1:0] r_mem [GENERIC_MEM_DEPTH];

  // NOTE: the storage array is deliberately not reset; the owner's pointers decide
  // which entries are valid, and a reset here would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  generate
    if (GENERIC_MEM_REGISTERED_OUT != 0) begin : g_reg_out
      logic [GENERIC_MEM_DATA_WIDTH-1:0] r_rd_data;
      always_ff @(posedge clk) begin
        r_rd_data <= r_mem[i_rd_addr];
      end
      assign o_rd_data = r_rd_data;
    end else begin : g_comb_out
      assign o_rd_data = r_mem[i_rd_addr];
    end
  endgenerate

endmodule

// File: rtl/generic_fifo_flow.sv
// Same-clock FIFO with exact count, true full, almost thresholds, arbitrary depth,
// optional first-word-fall-through output and sticky overflow/underflow flags.
module generic_fifo_flow
  import generic_fifo_flow_pkg::*;
#(
  parameter int FIFO_DEPTH        = 8,
  parameter int FIFO_DATA_WIDTH   = 32,
  parameter int FIFO_AF_THRESHOLD = 2,
  parameter int FIFO_AE_THRESHOLD = 2,
  parameter int FIFO_FWFT         = FIFO_MODE_STD,
  localparam int FIFO_ADDR_WIDTH  = safe_addr_width(FIFO_DEPTH),
  localparam int FIFO_COUNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic                        clear,
  input  logic                        write,
  input  logic [FIFO_DATA_WIDTH-1:0]  write_data,
  input  logic                        read,
  output logic [FIFO_DATA_WIDTH-1:0]  read_data,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [FIFO_COUNT_WIDTH-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam logic [FIFO_ADDR_WIDTH-1:0]  LAST_ADDR = FIFO_ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [FIFO_COUNT_WIDTH-1:0] ONE       = FIFO_COUNT_WIDTH'(1);
  localparam logic                        AF_RESET  = (FIFO_DEPTH <= FIFO_AF_THRESHOLD);

  logic [FIFO_ADDR_WIDTH-1:0]  r_wp, r_rp;
  logic [FIFO_COUNT_WIDTH-1:0] r_count;
  logic                        r_empty, r_full, r_almost_full, r_almost_empty;
  logic [FIFO_DATA_WIDTH-1:0]  r_read_data;
  logic                        r_overflow, r_underflow;

  logic                        w_rd_ok, w_wr_ok;
  logic [FIFO_ADDR_WIDTH-1:0]  w_wp_next, w_rp_next, w_mem_rd_addr;
  logic [FIFO_COUNT_WIDTH-1:0] w_count_next;
  logic [FIFO_DATA_WIDTH-1:0]  w_mem_rd_data;
  logic                        w_load_bypass, w_load_mem;

  assign w_rd_ok   = read & ~r_empty;
  assign w_wr_ok   = write & (~r_full | w_rd_ok);
  assign w_wp_next = (r_wp == LAST_ADDR) ? '0 : r_wp + 1'b1;
  assign w_rp_next = (r_rp == LAST_ADDR) ? '0 : r_rp + 1'b1;

  // FWFT prefetches the entry behind the head; standard mode reads the head itself.
  // Either way the read address differs from the write address whenever the read
  // result is used, except standard mode at full where the old word is returned.
  assign w_mem_rd_addr = (FIFO_FWFT == FIFO_MODE_FWFT) ? w_rp_next : r_rp;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_count_next  = r_count;
    w_load_bypass = 1'b0;
    w_load_mem    = 1'b0;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_next = r_count + ONE;
      2'b01:   w_count_next = r_count - ONE;
      default: w_count_next = r_count;
    endcase
    if (FIFO_FWFT == FIFO_MODE_FWFT) begin
      w_load_bypass = w_wr_ok & (r_empty | (w_rd_ok & (r_count == ONE)));
      w_load_mem    = w_rd_ok & (r_count > ONE);
    end else begin
      w_load_mem    = w_rd_ok;
    end
  end

  generic_2port_memory #(
    .GENERIC_MEM_DEPTH         (FIFO_DEPTH),
    .GENERIC_MEM_DATA_WIDTH    (FIFO_DATA_WIDTH),
    .GENERIC_MEM_REGISTERED_OUT(0)
  ) u_mem (
    .clk      (clk),
    .i_wr_en  (w_wr_ok & ~clear & ~reset_poweron),
    .i_wr_addr(r_wp),
    .i_wr_data(write_data),
    .i_rd_addr(w_mem_rd_addr),
    .o_rd_data(w_mem_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset_poweron || clear) begin
      r_wp           <= '0;
      r_rp           <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= AF_RESET;
      r_almost_empty <= 1'b1;
      r_read_data    <= '0;
    end else begin
      if (w_wr_ok) r_wp <= w_wp_next;
      if (w_rd_ok) r_rp <= w_rp_next;
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (int'(w_count_next) == FIFO_DEPTH);
      r_almost_full  <= ((FIFO_DEPTH - int'(w_count_next)) <= FIFO_AF_THRESHOLD);
      r_almost_empty <= (int'(w_count_next) <= FIFO_AE_THRESHOLD);
      if (w_load_bypass)   r_read_data <= write_data;
      else if (w_load_mem) r_read_data <= w_mem_rd_data;
    end
  end

  // Error flags survive a flush; only power-on reset clears them.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!clear) begin
      if (write && !w_wr_ok) r_overflow  <= 1'b1;
      if (read && !w_rd_ok)  r_underflow <= 1'b1;
    end
  end

  assign read_data    = r_read_data;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
